// File: rtl/gemm_tile_ctrl.sv
// Sequencer for the tile MAC array: walks (m, n, k) issues, generates operand
// SRAM addresses and array controls, and emits one C write per finished tile.
module gemm_tile_ctrl #(
  parameter int unsigned DimWidth  = 8,
  parameter int unsigned AddrWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DimWidth-1:0]  m_tiles_i,
  input  logic [DimWidth-1:0]  n_tiles_i,
  input  logic [DimWidth-1:0]  k_tiles_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AddrWidth-1:0] a_addr_o,
  output logic [AddrWidth-1:0] b_addr_o,
  output logic                 a_valid_o,
  output logic                 b_valid_o,
  output logic                 init_save_o,
  output logic                 acc_clr_o,
  output logic                 c_we_o,
  output logic [AddrWidth-1:0] c_addr_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [DimWidth-1:0]   m_tiles_q, m_tiles_d, n_tiles_q, n_tiles_d, k_tiles_q, k_tiles_d;
  logic [DimWidth-1:0]   m_q, m_d, n_q, n_d, k_q, k_d;
  logic [AddrWidth-1:0]  a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [AddrWidth-1:0]  a_base_q, a_base_d, tile_q, tile_d;
  logic                  valid_q, valid_d, init_q, init_d, acc_clr_q, acc_clr_d;
  logic                  s1_last_q, s1_last_d;
  logic [AddrWidth-1:0]  s1_caddr_q, s1_caddr_d;
  logic                  c_we_q, c_we_d;
  logic [AddrWidth-1:0]  c_addr_q, c_addr_d;
  logic                  last_k, last_n, last_m, dims_ok;

  assign last_k  = (k_q == k_tiles_q - DimWidth'(1));
  assign last_n  = (n_q == n_tiles_q - DimWidth'(1));
  assign last_m  = (m_q == m_tiles_q - DimWidth'(1));
  assign dims_ok = (|m_tiles_i) && (|n_tiles_i) && (|k_tiles_i);

  always_comb begin
    state_d    = state_q;
    m_tiles_d  = m_tiles_q;
    n_tiles_d  = n_tiles_q;
    k_tiles_d  = k_tiles_q;
    m_d        = m_q;
    n_d        = n_q;
    k_d        = k_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    a_base_d   = a_base_q;
    tile_d     = tile_q;
    valid_d    = 1'b0;
    init_d     = 1'b0;
    acc_clr_d  = 1'b0;
    s1_last_d  = 1'b0;
    s1_caddr_d = s1_caddr_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (dims_ok) begin
            state_d   = StRun;
            m_tiles_d = m_tiles_i;
            n_tiles_d = n_tiles_i;
            k_tiles_d = k_tiles_i;
            m_d       = '0;
            n_d       = '0;
            k_d       = '0;
            a_addr_d  = '0;
            b_addr_d  = '0;
            a_base_d  = '0;
            tile_d    = '0;
            acc_clr_d = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        valid_d    = 1'b1;
        init_d     = (k_q == '0);
        s1_last_d  = last_k;
        s1_caddr_d = tile_q;
        if (!last_k) begin
          k_d      = k_q + DimWidth'(1);
          a_addr_d = a_addr_q + AddrWidth'(1);
          b_addr_d = b_addr_q + AddrWidth'(n_tiles_q);
        end else if (!last_n) begin
          k_d      = '0;
          n_d      = n_q + DimWidth'(1);
          tile_d   = tile_q + AddrWidth'(1);
          a_addr_d = a_base_q;
          b_addr_d = AddrWidth'(n_q) + AddrWidth'(1);
        end else if (!last_m) begin
          // a_addr is already m*K + K-1, so the next row base is one past it.
          k_d      = '0;
          n_d      = '0;
          m_d      = m_q + DimWidth'(1);
          tile_d   = tile_q + AddrWidth'(1);
          a_addr_d = a_addr_q + AddrWidth'(1);
          a_base_d = a_addr_q + AddrWidth'(1);
          b_addr_d = '0;
        end else begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (c_we_q && !valid_q) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    c_we_d   = valid_q && s1_last_q;
    c_addr_d = c_we_d ? s1_caddr_q : c_addr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      m_tiles_q  <= '0;
      n_tiles_q  <= '0;
      k_tiles_q  <= '0;
      m_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      a_base_q   <= '0;
      tile_q     <= '0;
      valid_q    <= 1'b0;
      init_q     <= 1'b0;
      acc_clr_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_caddr_q <= '0;
      c_we_q     <= 1'b0;
      c_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      m_tiles_q  <= m_tiles_d;
      n_tiles_q  <= n_tiles_d;
      k_tiles_q  <= k_tiles_d;
      m_q        <= m_d;
      n_q        <= n_d;
      k_q        <= k_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      a_base_q   <= a_base_d;
      tile_q     <= tile_d;
      valid_q    <= valid_d;
      init_q     <= init_d;
      acc_clr_q  <= acc_clr_d;
      s1_last_q  <= s1_last_d;
      s1_caddr_q <= s1_caddr_d;
      c_we_q     <= c_we_d;
      c_addr_q   <= c_addr_d;
    end
  end

  assign busy_o      = (state_q == StRun) || (state_q == StDrain);
  assign done_o      = (state_q == StDone);
  assign a_addr_o    = a_addr_q;
  assign b_addr_o    = b_addr_q;
  assign a_valid_o   = valid_q;
  assign b_valid_o   = valid_q;
  assign init_save_o = init_q;
  assign acc_clr_o   = acc_clr_q;
  assign c_we_o      = c_we_q;
  assign c_addr_o    = c_addr_q;

endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// Directed bench for gemm_tile_ctrl; cycle numbers count from the accept edge.
module tb_gemm_tile_ctrl;
  logic        clk = 1'b0;
  logic        rst_i, start_i;
  logic [7:0]  m_tiles_i, n_tiles_i, k_tiles_i;
  logic        busy_o, done_o, a_valid_o, b_valid_o, init_save_o, acc_clr_o, c_we_o;
  logic [15:0] a_addr_o, b_addr_o, c_addr_o;
  int          total = 0;
  int          bad = 0;

  gemm_tile_ctrl #(.DimWidth(8), .AddrWidth(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .m_tiles_i(m_tiles_i), .n_tiles_i(n_tiles_i), .k_tiles_i(k_tiles_i),
    .busy_o(busy_o), .done_o(done_o), .a_addr_o(a_addr_o), .b_addr_o(b_addr_o),
    .a_valid_o(a_valid_o), .b_valid_o(b_valid_o), .init_save_o(init_save_o),
    .acc_clr_o(acc_clr_o), .c_we_o(c_we_o), .c_addr_o(c_addr_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 after the accept edge.
  task automatic kick(input int mm, input int nn, input int kk);
    m_tiles_i = 8'(mm);
    n_tiles_i = 8'(nn);
    k_tiles_i = 8'(kk);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [55:0] outs;
    rst_i = 1'b1; start_i = 1'b0; m_tiles_i = '0; n_tiles_i = '0; k_tiles_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    outs = {busy_o, done_o, a_addr_o, b_addr_o, a_valid_o, b_valid_o, init_save_o,
            acc_clr_o, c_we_o, c_addr_o, 1'b0};
    total++;
    if (outs !== 56'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", outs);
    end
  endtask

  task automatic test_minimal();
    kick(1, 1, 1);
    total++;
    if ({acc_clr_o, busy_o, a_valid_o, a_addr_o, b_addr_o} !== {3'b110, 32'h0}) begin
      bad++; $display("FAIL min_c1 clr=%b busy=%b v=%b a=%0d b=%0d want 1,1,0,0,0",
                      acc_clr_o, busy_o, a_valid_o, a_addr_o, b_addr_o);
    end
    tick();
    total++;
    if ({a_valid_o, b_valid_o, init_save_o, acc_clr_o, c_we_o} !== 5'b11100) begin
      bad++; $display("FAIL min_c2 v/init/clr/we got=%b want=11100",
                      {a_valid_o, b_valid_o, init_save_o, acc_clr_o, c_we_o});
    end
    tick();
    total++;
    if ({c_we_o, c_addr_o, a_valid_o, done_o, busy_o} !== {1'b1, 16'd0, 3'b001}) begin
      bad++; $display("FAIL min_c3 we=%b ca=%0d v=%b done=%b busy=%b want 1,0,0,0,1",
                      c_we_o, c_addr_o, a_valid_o, done_o, busy_o);
    end
    tick();
    total++;
    if ({done_o, busy_o, c_we_o} !== 3'b100) begin
      bad++; $display("FAIL min_c4 done/busy/we got=%b want=100", {done_o, busy_o, c_we_o});
    end
    tick();
    total++;
    if (done_o !== 1'b0) begin
      bad++; $display("FAIL min_c5 done got=%b want=0", done_o);
    end
  endtask

  task automatic test_gemm_2x3x4();
    int a_hand [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int b_hand [8] = '{0, 3, 6, 9, 1, 4, 7, 10};
    kick(2, 3, 4);
    for (int c = 1; c <= 28; c++) begin
      int i, ea, eb, ev, ei, ewe;
      i = c - 1;
      if (c <= 8) begin
        ea = a_hand[c-1]; eb = b_hand[c-1];
      end else begin
        ea = (i / 12) * 4 + (i % 4); eb = (i % 4) * 3 + ((i / 4) % 3);
      end
      if (c <= 24) begin
        total++;
        if (a_addr_o !== 16'(ea) || b_addr_o !== 16'(eb)) begin
          bad++; $display("FAIL g234_addr c=%0d a=%0d b=%0d want a=%0d b=%0d",
                          c, a_addr_o, b_addr_o, ea, eb);
        end
      end
      ev  = (c >= 2 && c <= 25) ? 1 : 0;
      ei  = (ev == 1 && (c - 2) % 4 == 0) ? 1 : 0;
      ewe = (c >= 6 && c <= 26 && (c - 6) % 4 == 0) ? 1 : 0;
      total++;
      if (a_valid_o !== 1'(ev) || b_valid_o !== 1'(ev) || init_save_o !== 1'(ei) ||
          c_we_o !== 1'(ewe) || done_o !== (c == 27) || busy_o !== (c <= 26) ||
          acc_clr_o !== (c == 1)) begin
        bad++; $display("FAIL g234_ctrl c=%0d v=%b%b init=%b we=%b done=%b busy=%b clr=%b want v=%0d init=%0d we=%0d",
                        c, a_valid_o, b_valid_o, init_save_o, c_we_o, done_o, busy_o,
                        acc_clr_o, ev, ei, ewe);
      end
      if (ewe == 1) begin
        total++;
        if (c_addr_o !== 16'((c - 6) / 4)) begin
          bad++; $display("FAIL g234_caddr c=%0d got=%0d want=%0d", c, c_addr_o, (c - 6) / 4);
        end
      end
      tick();
    end
  endtask

  task automatic test_zero();
    kick(3, 2, 0);
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (done_o !== (c == 1) || busy_o !== 1'b0 || a_valid_o !== 1'b0 ||
          c_we_o !== 1'b0 || acc_clr_o !== 1'b0) begin
        bad++; $display("FAIL zero_dim c=%0d done=%b busy=%b v=%b we=%b clr=%b want done=%0d",
                        c, done_o, busy_o, a_valid_o, c_we_o, acc_clr_o, c == 1);
      end
      tick();
    end
  endtask

  task automatic test_k1_stream();
    kick(1, 4, 1);
    for (int c = 1; c <= 8; c++) begin
      logic ev, ewe;
      ev  = (c >= 2 && c <= 5);
      ewe = (c >= 3 && c <= 6);
      total++;
      if (a_valid_o !== ev || init_save_o !== ev || c_we_o !== ewe || done_o !== (c == 7) ||
          (ewe && c_addr_o !== 16'(c - 3))) begin
        bad++; $display("FAIL k1_stream c=%0d v=%b init=%b we=%b ca=%0d done=%b want v=%b we=%b ca=%0d",
                        c, a_valid_o, init_save_o, c_we_o, c_addr_o, done_o, ev, ewe, c - 3);
      end
      tick();
    end
  endtask

  // 2x2x2 job: C writes at cycles 4,6,8,10 with addresses 0..3, done at 11.
  task automatic test_busy_start();
    int nwe = 0;
    kick(2, 2, 2);
    m_tiles_i = 8'd9; n_tiles_i = 8'd9; k_tiles_i = 8'd9;
    for (int c = 1; c <= 11; c++) begin
      logic ewe;
      start_i = (c == 3 || c == 7);
      ewe = (c >= 4 && c <= 10 && c % 2 == 0);
      if (c_we_o) nwe++;
      total++;
      if (c_we_o !== ewe || (ewe && c_addr_o !== 16'((c - 4) / 2)) || done_o !== (c == 11) ||
          busy_o !== (c <= 10)) begin
        bad++; $display("FAIL busy_start c=%0d we=%b ca=%0d done=%b busy=%b want we=%b ca=%0d",
                        c, c_we_o, c_addr_o, done_o, busy_o, ewe, (c - 4) / 2);
      end
      tick();
    end
    start_i = 1'b0;
    total++;
    if (nwe != 4) begin
      bad++; $display("FAIL busy_start_count got=%0d want=4", nwe);
    end
    kick(1, 1, 1);
    total++;
    if (busy_o !== 1'b1 || acc_clr_o !== 1'b1) begin
      bad++; $display("FAIL start_after_done busy=%b clr=%b want 1,1", busy_o, acc_clr_o);
    end
    tick(); tick(); tick();
    total++;
    if (done_o !== 1'b1) begin
      bad++; $display("FAIL start_after_done_end done=%b want=1", done_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [55:0] outs;
    kick(2, 2, 2);
    tick(); tick(); tick(); tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    outs = {busy_o, done_o, a_addr_o, b_addr_o, a_valid_o, b_valid_o, init_save_o,
            acc_clr_o, c_we_o, c_addr_o, 1'b0};
    total++;
    if (outs !== 56'h0) begin
      bad++; $display("FAIL reset_mid_outputs got=%h want=0", outs);
    end
    for (int c = 0; c < 8; c++) begin
      total++;
      if (c_we_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++; $display("FAIL reset_mid_quiet t=%0d we=%b done=%b busy=%b want 0",
                        c, c_we_o, done_o, busy_o);
      end
      tick();
    end
    kick(2, 2, 2);
    for (int c = 1; c <= 11; c++) begin
      logic ewe;
      ewe = (c >= 4 && c <= 10 && c % 2 == 0);
      total++;
      if (c_we_o !== ewe || (ewe && c_addr_o !== 16'((c - 4) / 2)) || done_o !== (c == 11) ||
          acc_clr_o !== (c == 1)) begin
        bad++; $display("FAIL reset_rerun c=%0d we=%b ca=%0d done=%b clr=%b want we=%b",
                        c, c_we_o, c_addr_o, done_o, acc_clr_o, ewe);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_minimal();
    test_gemm_2x3x4();
    test_zero();
    test_k1_stream();
    test_busy_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gemm_tile_ctrl.md
# gemm_tile_ctrl

Sequencer for the sqDim×sqDim tile MAC array in the GEMM accelerator. Given a job of M×N output tiles with a K-tile reduction depth, it walks every (m, n, k) triple, issues A/B tile read addresses to the operand SRAMs, and drives the array's a_valid/b_valid/init_save/acc_clr controls. It then emits a C write strobe and address per finished output tile. The datapath runs fully pipelined, one K-beat per cycle with no bubbles between output tiles.

## Interface
- DimWidth, 8: width of the M/N/K tile-count inputs.
- AddrWidth, 16: width of all SRAM tile addresses (addresses are in tile units).
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  job request; accepted only in IDLE.
- m_tiles_i / n_tiles_i / k_tiles_i  in  DimWidth  job dimensions in tiles; latched on accept.
- busy_o  out  1  high from the cycle after accept through the cycle of the last c_we_o.
- done_o  out  1  one-cycle pulse at job end.
- a_addr_o / b_addr_o  out  AddrWidth  operand SRAM read addresses; the SRAM has 1-cycle read latency.
- a_valid_o / b_valid_o  out  1  to the array; high the cycle the read data arrives.
- init_save_o  out  1  to the array; high on the first K-beat of each output tile (the accumulator loads instead of adding).
- acc_clr_o  out  1  to the array; one-cycle clear at job start.
- c_we_o  out  1  C SRAM write strobe; the array output is valid this cycle.
- c_addr_o  out  AddrWidth  C tile write address.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - If start_i is high and all dimensions are nonzero: latch the dimensions, clear the m/n/k counters, and go to RUN.
  - If start_i is high and any dimension is 0: go to DONE, with no array or SRAM activity.
  - start_i is ignored in every other state.
- **RUN**, one issue per cycle:
  - Loop order is m outer, n middle, k inner.
  - a_addr_o = m·K + k; b_addr_o = k·N + n.
  - Both addresses are maintained by running-base increments (no multipliers) and wrap modulo 2^AddrWidth.
  - After issuing (M-1, N-1, K-1), go to DRAIN.
- **Pipeline**, for an issue in cycle t:
  - Stage 1 (t+1): a_valid_o and b_valid_o are high; init_save_o is high iff k was 0.
  - Stage 2 (t+2): only if k was K-1, c_we_o is high with c_addr_o = m·N + n.
  - a_valid_o and b_valid_o are always driven identically.
- **DRAIN**: wait until the final c_we_o has been emitted, then go to DONE.
- **DONE**: done_o is high for one cycle, then go to IDLE.
- acc_clr_o is high for exactly the first cycle after accept, which is the first RUN cycle.
- Back-to-back output tiles:
  - The next tile's init_save_o beat coincides with the previous tile's c_we_o cycle.
  - This is legal because the array output register still holds the finished sum during that cycle.
- Reset mid-job: the pipeline is squashed, all outputs are forced low or zero from the next edge, and the state returns to IDLE. No c_we_o is emitted for partial tiles.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Start accepted at edge 0. Define P = M·N·K:
  - Issues occupy cycles 1..P.
  - First valid is in cycle 2.
  - Last c_we_o is in cycle P+2.
  - done_o pulses in cycle P+3.
  - busy_o is high in cycles 1..P+2.
- Zero-dimension job: done_o pulses in cycle 1 and busy_o stays low.
- Address outputs hold their last value when not issuing. They carry no meaning unless the corresponding valid/strobe stage follows.
- Per job, the number of c_we_o pulses is M·N, and every output tile's C write is exactly 2 cycles after its last K issue.

## Test plan
- **Minimal job:** M=N=K=1, start at edge 0.
  - Cycle 1: acc_clr_o=1, a_addr=b_addr=0.
  - Cycle 2: valid=1 and init_save=1.
  - Cycle 3: c_we=1 with c_addr=0.
  - Cycle 4: done_o=1.
- **M=2, N=3, K=4:**
  - 24 consecutive issue cycles.
  - a_addr sequence starts 0,1,2,3,0,1,2,3,… and b_addr starts 0,3,6,9,1,4,7,10,…
  - init_save is high on every 4th valid beat.
  - c_addr is 0..5 in order at cycles 6,10,14,18,22,26.
  - done_o=1 in cycle 27.
- **Zero dimension:** K=0 with start → done_o in cycle 1; no valid, no c_we, and busy stays 0.
- **Start while busy:** pulse start_i mid-job with different dimensions → ignored; the original job completes unchanged. A start in the cycle after done_o is accepted.
- **Reset mid-job:** assert rst_i at cycle 5 of the M=N=K=2 job → the following cycle has all outputs at 0 and the state is IDLE. No further c_we_o appears, and a fresh start runs correctly.
- **K=1 streaming:** M=1, N=4.
  - c_we is high in cycles 3..6 with c_addr 0..3.
  - init_save is high on every valid beat.
